// File: rtl/vchess_pkg.sv
// rtl/vchess_pkg.sv - piece encodings, engine states and square-index helpers
package vchess_pkg;

  localparam int PIECE_WIDTH_DEFAULT = 4;
  localparam int SIDE_BIT            = 3;

  typedef enum logic [2:0] {
    PT_EMPTY  = 3'd0,
    PT_PAWN   = 3'd1,
    PT_KNIGHT = 3'd2,
    PT_BISHOP = 3'd3,
    PT_ROOK   = 3'd4,
    PT_QUEEN  = 3'd5,
    PT_KING   = 3'd6
  } piece_type_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } engine_state_e;

  function automatic int sq_row(input logic [5:0] sq);
    return int'(sq[5:3]);
  endfunction

  function automatic int sq_col(input logic [5:0] sq);
    return int'(sq[2:0]);
  endfunction

  function automatic logic on_board(input int r, input int c);
    return (r >= 0) && (r < 8) && (c >= 0) && (c < 8);
  endfunction

  function automatic int sq_index(input int r, input int c);
    return r * 8 + c;
  endfunction

endpackage

// File: rtl/square_attack_eval.sv
// rtl/square_attack_eval.sv - combinational "is this square attacked" check for both colours
module square_attack_eval
  import vchess_pkg::*;
#(
  parameter int PIECE_WIDTH = PIECE_WIDTH_DEFAULT,
  parameter int BOARD_WIDTH = 64 * PIECE_WIDTH
) (
  input  logic [BOARD_WIDTH-1:0] board,
  input  logic [5:0]             sq,
  output logic                   attacked_by_white,
  output logic                   attacked_by_black
);

  localparam int KN_DR [8] = '{ 1,  2,  2,  1, -1, -2, -2, -1};
  localparam int KN_DC [8] = '{ 2,  1, -1, -2, -2, -1,  1,  2};

  function automatic logic [PIECE_WIDTH-1:0] piece_at(input logic [BOARD_WIDTH-1:0] b,
                                                      input int r, input int c);
    return b[sq_index(r, c) * PIECE_WIDTH +: PIECE_WIDTH];
  endfunction

  // Looks outward from the target square for a piece that could reach it.
  always_comb begin
    logic [PIECE_WIDTH-1:0] p;
    int   r, c, tr, tc;
    logic blocked;
    attacked_by_white = 1'b0;
    attacked_by_black = 1'b0;
    p       = '0;
    tr      = 0;
    tc      = 0;
    blocked = 1'b0;
    r = sq_row(sq);
    c = sq_col(sq);

    for (int dc = -1; dc <= 1; dc += 2) begin
      if (on_board(r - 1, c + dc)) begin
        p = piece_at(board, r - 1, c + dc);
        if (p[2:0] == PT_PAWN && !p[SIDE_BIT]) attacked_by_white = 1'b1;
      end
      if (on_board(r + 1, c + dc)) begin
        p = piece_at(board, r + 1, c + dc);
        if (p[2:0] == PT_PAWN && p[SIDE_BIT]) attacked_by_black = 1'b1;
      end
    end

    for (int k = 0; k < 8; k++) begin
      if (on_board(r + KN_DR[k], c + KN_DC[k])) begin
        p = piece_at(board, r + KN_DR[k], c + KN_DC[k]);
        if (p[2:0] == PT_KNIGHT) begin
          if (p[SIDE_BIT]) attacked_by_black = 1'b1;
          else             attacked_by_white = 1'b1;
        end
      end
    end

    // King shares the ray walk: it is a slider limited to distance 1.
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        if (!(dr == 0 && dc == 0)) begin
          blocked = 1'b0;
          for (int d = 1; d < 8; d++) begin
            tr = r + dr * d;
            tc = c + dc * d;
            if (!blocked && on_board(tr, tc)) begin
              p = piece_at(board, tr, tc);
              if ((p[2:0] == PT_QUEEN) ||
                  (p[2:0] == PT_KING && d == 1) ||
                  (p[2:0] == PT_ROOK && (dr == 0 || dc == 0)) ||
                  (p[2:0] == PT_BISHOP && dr != 0 && dc != 0)) begin
                if (p[SIDE_BIT]) attacked_by_black = 1'b1;
                else             attacked_by_white = 1'b1;
              end
              if (p[2:0] != PT_EMPTY) blocked = 1'b1;
            end
          end
        end
      end
    end
  end

endmodule

// File: rtl/attack_map_engine.sv
// rtl/attack_map_engine.sv - time-multiplexed attack-map engine with check/legality flags
module attack_map_engine
  import vchess_pkg::*;
#(
  parameter int PIECE_WIDTH       = PIECE_WIDTH_DEFAULT,
  parameter int SIDE_WIDTH        = 1,
  parameter int BOARD_WIDTH       = 64 * PIECE_WIDTH,
  parameter int SQUARES_PER_CYCLE = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [BOARD_WIDTH-1:0] board,
  input  logic                   board_valid,
  input  logic                   white_to_move,
  output logic                   board_ready,
  output logic [63:0]            attacked_white,
  output logic [63:0]            attacked_black,
  output logic                   white_in_check,
  output logic                   black_in_check,
  output logic                   illegal,
  output logic                   king_error,
  output logic                   out_valid,
  input  logic                   out_ready
);

  localparam int SPC = SQUARES_PER_CYCLE;
  localparam logic [5:0] STEP     = 6'(SPC % 64);
  localparam logic [5:0] LAST_IDX = 6'(64 - SPC);

  if (SPC < 1 || SPC > 64 || (SPC & (SPC - 1)) != 0) begin : g_bad_spc
    $error("SQUARES_PER_CYCLE must be a power of two in 1..64");
  end
  if (SIDE_WIDTH != 1) begin : g_bad_side
    $error("SIDE_WIDTH must be 1");
  end

  engine_state_e          state;
  logic [5:0]             idx;
  logic [BOARD_WIDTH-1:0] board_q;
  logic                   wtm_q;
  logic [1:0]             wk_cnt, bk_cnt;
  logic [5:0]             wk_idx, bk_idx;

  logic [SPC-1:0] aw_k, ab_k;
  logic [5:0]     sq_k [SPC];

  for (genvar k = 0; k < SPC; k++) begin : g_eval
    assign sq_k[k] = idx + 6'(k);
    square_attack_eval #(
      .PIECE_WIDTH (PIECE_WIDTH),
      .BOARD_WIDTH (BOARD_WIDTH)
    ) u_eval (
      .board             (board_q),
      .sq                (sq_k[k]),
      .attacked_by_white (aw_k[k]),
      .attacked_by_black (ab_k[k])
    );
  end

  logic [63:0] aw_n, ab_n;
  logic [1:0]  wk_cnt_n, bk_cnt_n;
  logic [5:0]  wk_idx_n, bk_idx_n;
  logic        w_chk_n, b_chk_n;

  // Maps and king bookkeeping as they will stand after this scan slice,
  // so the final slice can derive the flags on its own transition.
  always_comb begin
    logic [PIECE_WIDTH-1:0] pc;
    pc       = '0;
    aw_n     = attacked_white;
    ab_n     = attacked_black;
    wk_cnt_n = wk_cnt;
    bk_cnt_n = bk_cnt;
    wk_idx_n = wk_idx;
    bk_idx_n = bk_idx;
    for (int k = 0; k < SPC; k++) begin
      pc = board_q[int'(sq_k[k]) * PIECE_WIDTH +: PIECE_WIDTH];
      aw_n[sq_k[k]] = aw_k[k];
      ab_n[sq_k[k]] = ab_k[k];
      if (pc[2:0] == PT_KING) begin
        if (pc[SIDE_BIT]) begin
          if (bk_cnt_n != 2'd2) bk_cnt_n = bk_cnt_n + 2'd1;
          bk_idx_n = sq_k[k];
        end else begin
          if (wk_cnt_n != 2'd2) wk_cnt_n = wk_cnt_n + 2'd1;
          wk_idx_n = sq_k[k];
        end
      end
    end
    w_chk_n = (wk_cnt_n == 2'd1) && ab_n[wk_idx_n];
    b_chk_n = (bk_cnt_n == 2'd1) && aw_n[bk_idx_n];
  end

  assign board_ready = (state == ST_IDLE);
  assign out_valid   = (state == ST_DONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= ST_IDLE;
      idx            <= '0;
      board_q        <= '0;
      wtm_q          <= 1'b0;
      wk_cnt         <= '0;
      bk_cnt         <= '0;
      wk_idx         <= '0;
      bk_idx         <= '0;
      attacked_white <= '0;
      attacked_black <= '0;
      white_in_check <= 1'b0;
      black_in_check <= 1'b0;
      illegal        <= 1'b0;
      king_error     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (board_valid) begin
            board_q        <= board;
            wtm_q          <= white_to_move;
            attacked_white <= '0;
            attacked_black <= '0;
            wk_cnt         <= '0;
            bk_cnt         <= '0;
            wk_idx         <= '0;
            bk_idx         <= '0;
            white_in_check <= 1'b0;
            black_in_check <= 1'b0;
            illegal        <= 1'b0;
            king_error     <= 1'b0;
            idx            <= '0;
            state          <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          attacked_white <= aw_n;
          attacked_black <= ab_n;
          wk_cnt         <= wk_cnt_n;
          bk_cnt         <= bk_cnt_n;
          wk_idx         <= wk_idx_n;
          bk_idx         <= bk_idx_n;
          idx            <= idx + STEP;
          if (idx == LAST_IDX) begin
            white_in_check <= w_chk_n;
            black_in_check <= b_chk_n;
            illegal        <= wtm_q ? b_chk_n : w_chk_n;
            king_error     <= (wk_cnt_n != 2'd1) || (bk_cnt_n != 2'd1);
            state          <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_attack_map_engine.sv
// tb/tb_attack_map_engine.sv - directed self-checking bench for attack_map_engine
module tb_attack_map_engine;

  localparam int SPC_TAB [3] = '{1, 8, 64};
  localparam logic [3:0] W_PAWN = 4'h1, W_ROOK = 4'h4, W_KING = 4'h6;
  localparam logic [3:0] B_PAWN = 4'h9, B_ROOK = 4'hC, B_KING = 4'hE;

  logic         clk = 1'b0;
  logic         reset;
  logic [255:0] board;
  logic         wtm;
  logic         bv [3];
  logic         ordy [3];
  logic         brdy [3], ov [3], wic [3], bic [3], ill [3], kerr [3];
  logic [63:0]  aw [3], ab [3];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    attack_map_engine #(.SQUARES_PER_CYCLE(SPC_TAB[g])) u_dut (
      .clk            (clk),
      .reset          (reset),
      .board          (board),
      .board_valid    (bv[g]),
      .white_to_move  (wtm),
      .board_ready    (brdy[g]),
      .attacked_white (aw[g]),
      .attacked_black (ab[g]),
      .white_in_check (wic[g]),
      .black_in_check (bic[g]),
      .illegal        (ill[g]),
      .king_error     (kerr[g]),
      .out_valid      (ov[g]),
      .out_ready      (ordy[g])
    );
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] put(input logic [255:0] b, input int sq, input logic [3:0] p);
    logic [255:0] r;
    r = b;
    r[sq*4 +: 4] = p;
    return r;
  endfunction

  task automatic run_board(input int g, input logic [255:0] b, input logic w, input int exp_lat);
    int lat;
    @(negedge clk);
    board = b;
    wtm   = w;
    bv[g] = 1'b1;
    @(posedge clk); #1;
    bv[g] = 1'b0;
    lat = 1;
    while (!ov[g] && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check($sformatf("latency spc=%0d", SPC_TAB[g]), 64'(lat), 64'(exp_lat));
  endtask

  task automatic pop_result(input int g);
    @(negedge clk);
    ordy[g] = 1'b1;
    @(posedge clk); #1;
    ordy[g] = 1'b0;
    check("board_ready after pop", 64'(brdy[g]), 64'd1);
    check("out_valid after pop", 64'(ov[g]), 64'd0);
  endtask

  logic [255:0] kings, rook_b, pawn_b, twok_b, nobk_b;
  localparam logic [63:0] AW_KINGS = 64'h0000_0000_0000_3828;
  localparam logic [63:0] AB_KINGS = 64'h2838_0000_0000_0000;
  localparam logic [63:0] AW_ROOK  = 64'h1E01_0101_0101_3929;
  localparam logic [63:0] AW_PAWN  = 64'h0000_0000_0040_3828;
  localparam logic [63:0] AB_PAWN  = 64'h2838_0200_0000_0000;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    board = '0;
    wtm   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bv[i]   = 1'b0;
      ordy[i] = 1'b0;
    end
    kings  = put(put(256'd0, 4, W_KING), 60, B_KING);
    rook_b = put(kings, 56, W_ROOK);
    pawn_b = put(put(kings, 15, W_PAWN), 48, B_PAWN);
    twok_b = put(put(kings, 12, W_KING), 52, B_ROOK);
    nobk_b = put(put(256'd0, 4, W_KING), 8, W_ROOK);

    repeat (3) @(posedge clk);
    #1;
    check("reset board_ready", 64'(brdy[1]), 64'd1);
    check("reset out_valid", 64'(ov[1]), 64'd0);
    check("reset attacked_white", aw[1], 64'd0);
    check("reset attacked_black", ab[1], 64'd0);
    check("reset flags", {60'd0, wic[1], bic[1], ill[1], kerr[1]}, 64'd0);
    @(negedge clk);
    reset = 1'b1;

    for (int g = 0; g < 3; g++) begin
      run_board(g, kings, 1'b1, 64 / SPC_TAB[g] + 1);
      check("kings attacked_white", aw[g], AW_KINGS);
      check("kings attacked_black", ab[g], AB_KINGS);
      check("kings flags", {60'd0, wic[g], bic[g], ill[g], kerr[g]}, 64'd0);
      pop_result(g);
    end

    run_board(1, rook_b, 1'b1, 9);
    check("rook attacked_white", aw[1], AW_ROOK);
    check("rook attacked_black", ab[1], AB_KINGS);
    check("rook black_in_check", 64'(bic[1]), 64'd1);
    check("rook white_in_check", 64'(wic[1]), 64'd0);
    check("rook illegal wtm=1", 64'(ill[1]), 64'd1);
    check("rook bit61 clear", 64'(aw[1][61]), 64'd0);
    pop_result(1);
    run_board(1, rook_b, 1'b0, 9);
    check("rook illegal wtm=0", 64'(ill[1]), 64'd0);
    check("rook black_in_check wtm=0", 64'(bic[1]), 64'd1);
    pop_result(1);

    run_board(1, pawn_b, 1'b0, 9);
    check("pawn attacked_white", aw[1], AW_PAWN);
    check("pawn attacked_black", ab[1], AB_PAWN);
    check("pawn no wrap bit24", 64'(aw[1][24]), 64'd0);
    check("pawn no wrap bit47", 64'(ab[1][47]), 64'd0);
    pop_result(1);

    run_board(1, rook_b, 1'b1, 9);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      bv[1] = ~bv[1];
      board = (i % 2 == 0) ? pawn_b : twok_b;
      wtm   = ~wtm;
      @(posedge clk); #1;
      check("hold board_ready", 64'(brdy[1]), 64'd0);
      check("hold attacked_white", aw[1], AW_ROOK);
      check("hold illegal/out_valid", {62'd0, ill[1], ov[1]}, 64'd3);
    end
    @(negedge clk);
    bv[1] = 1'b0;
    pop_result(1);
    run_board(1, pawn_b, 1'b1, 9);
    check("after hold attacked_white", aw[1], AW_PAWN);
    check("after hold attacked_black", ab[1], AB_PAWN);
    pop_result(1);

    @(negedge clk);
    board = kings;
    wtm   = 1'b1;
    bv[1] = 1'b1;
    @(posedge clk); #1;
    bv[1] = 1'b0;
    @(posedge clk);
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    check("abort out_valid", 64'(ov[1]), 64'd0);
    check("abort attacked_white", aw[1], 64'd0);
    check("abort attacked_black", ab[1], 64'd0);
    check("abort board_ready", 64'(brdy[1]), 64'd1);
    @(negedge clk);
    reset = 1'b1;
    run_board(1, kings, 1'b1, 9);
    check("post-abort attacked_white", aw[1], AW_KINGS);
    check("post-abort attacked_black", ab[1], AB_KINGS);
    pop_result(1);

    run_board(1, twok_b, 1'b1, 9);
    check("two wk attacked_white", aw[1], 64'h0000_0000_0038_3838);
    check("two wk king_error", 64'(kerr[1]), 64'd1);
    check("two wk white_in_check", 64'(wic[1]), 64'd0);
    check("two wk black_in_check", 64'(bic[1]), 64'd0);
    pop_result(1);

    run_board(1, nobk_b, 1'b1, 9);
    check("no bk king_error", 64'(kerr[1]), 64'd1);
    check("no bk black_in_check", 64'(bic[1]), 64'd0);
    check("no bk illegal", 64'(ill[1]), 64'd0);
    pop_result(1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/attack_map_engine.md
Name: attack_map_engine

Overview:
Multi-cycle attack-map engine that accepts a full board over a valid/ready handshake and produces 64-bit "attacked by white" and "attacked by black" maps, plus king-in-check, illegal-position and king-count flags. The SQUARES_PER_CYCLE parameter trades area against latency by time-multiplexing a per-square evaluator across the board. It sits between the board source and move generation/legality filtering and replaces the fully parallel 128-instance attack array.

Parameters:
PIECE_WIDTH, 4, bits per square: [3] side (1=black), [2:0] type (0 empty, 1 pawn, 2 knight, 3 bishop, 4 rook, 5 queen, 6 king)
SIDE_WIDTH, 1, width of the side field
BOARD_WIDTH, 64*PIECE_WIDTH, packed board; square idx=row*8+col, row 0 = rank 1, col 0 = file a; board[idx*PIECE_WIDTH +: PIECE_WIDTH]
SQUARES_PER_CYCLE, 8, squares evaluated per SCAN cycle; power of two, 1..64; any other value is an elaboration error

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
board  in  BOARD_WIDTH  input position
board_valid  in  1  board and white_to_move valid
white_to_move  in  1  side to move for the offered board
board_ready  out  1  engine can accept a board
attacked_white  out  64  bit idx set if any white piece attacks square idx
attacked_black  out  64  same, for black pieces
white_in_check  out  1  white king square set in attacked_black
black_in_check  out  1  black king square set in attacked_white
illegal  out  1  side not to move is in check
king_error  out  1  white or black king count != 1
out_valid  out  1  result outputs valid
out_ready  in  1  consumer accepts the result

Behaviour:
- Reset (reset=0, async): state=IDLE, idx=0, every output register=0; board_ready=1 (decoded from state).
- States IDLE, SCAN, DONE. board_ready = (state==IDLE); out_valid = (state==DONE).
- IDLE: on board_valid&&board_ready, latch board and white_to_move, clear maps and king counters, idx<=0, go to SCAN.
- SCAN: each cycle evaluate squares idx..idx+SPC-1 for both colours and write their bits; count kings seen (per colour, saturating at 2) and record the king index. idx+=SPC. The cycle that handles idx+SPC==64 transitions to DONE; flags are computed on that same transition.
- Latency: acceptance edge to out_valid=1 is exactly 64/SPC+1 cycles (SPC=64: 2; SPC=8: 9; SPC=1: 65).
- DONE: all outputs held stable until out_valid&&out_ready; then return to IDLE. A new board is accepted no earlier than the following cycle.
- board_valid is ignored while board_ready=0 (no latching, no effect); the source holds its data.
- Attack rules: pawns attack diagonally forward (white row+1, black row-1); knights and kings use standard offsets; bishop, rook and queen slide until the first occupied square, which is marked (either colour). There is no file or row wrap-around; off-board targets are dropped.
- A square is attacked independently of what occupies it; a side's own pieces can be "attacked" (defended).
- Flags: if king count for a colour != 1, king_error=1 and that colour's in_check=0. illegal = white_to_move ? black_in_check : white_in_check.
- Reset during SCAN or DONE aborts immediately; the partial result is never presented.

Decomposition:
- Package vchess_pkg: piece type codes, side bit position, PIECE_WIDTH default, and square-index helpers (row/col extract, on-board check).
- Sub-module square_attack_eval (combinational, params PIECE_WIDTH/BOARD_WIDTH): inputs board and a 6-bit square index; outputs attacked_by_white and attacked_by_black. The engine instantiates SQUARES_PER_CYCLE copies in a generate loop.

Test Plan:
- Kings only, e1 (4) and e8 (60), SPC=1/8/64 -> attacked_white=0x0000_0000_0000_3828, attacked_black=0x2838_0000_0000_0000, all flags 0; out_valid after 65/9/2 cycles.
- Test 1 plus white rook a8 (56): with white_to_move=1 -> black_in_check=1, illegal=1, attacked_white bits 57..60 set, bit 61 clear; with white_to_move=0 -> illegal=0.
- Kings e1/e8 plus white pawn h2 (15) -> bit 22 set in attacked_white, bit 24 clear (no wrap); black pawn a7 (48) -> bit 41 set in attacked_black, bit 47 clear.
- Hold out_ready=0 for 20 cycles in DONE while toggling board_valid with other boards -> outputs unchanged, board_ready=0; raise out_ready -> IDLE next cycle, and the next board is processed with correct results.
- Assert reset on the third SCAN cycle -> out_valid=0, maps=0, board_ready=1 while reset is low; after release, a fresh board yields correct maps.
- Two white kings (4, 12) plus black king 60 -> king_error=1, white_in_check=0; no black king -> king_error=1, black_in_check=0.
